flash_pe_ctrl: RTL and testbench



---
 rtl/flash_pe_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_flash_pe_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_pe_ctrl.sv
// flash_pe_ctrl: NOR-style flash macro model with req/gnt controller.
// Reads, multi-cycle programs (bits only clear), and page erase that sweeps one word per cycle.
// Ports: clk_i, rst_ni (async, active-low)
//   req_i, op_i, addr_i, wdata_i, wmask_i -> request; gnt_o accepts it
//   rdata_o/rvalid_o -> read result; done_o/err_o -> completion; busy_o
// Optional: define FLASH_PROG_CHECK_EN to reject programs that try to set a bit 0->1.
module flash_pe_ctrl #(
    parameter int Width           = 32,
    parameter int Depth           = 8192,
    parameter int DataBitsPerMask = 8,
    parameter int PageWords       = 256,
    parameter int ProgCycles      = 4,
    localparam int Aw             = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [1:0]       op_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic             gnt_o,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int Lanes = Width / DataBitsPerMask;
    localparam int Pw    = $clog2(PageWords);
    localparam int Cw    = (ProgCycles > 1) ? $clog2(ProgCycles) : 1;
    localparam logic [Cw-1:0] ProgLast = Cw'(ProgCycles - 1);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpProg  = 2'b01;
    localparam logic [1:0] OpErase = 2'b10;
    localparam logic [1:0] OpRsvd  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_PROG,
        ST_ERASE,
        ST_FIN
    } state_e;

    // Erased flash reads as all ones.
    logic [Width-1:0] mem [Depth] = '{default: '1};

    state_e           state_q;
    logic [Aw-1:0]    addr_q;
    logic [Width-1:0] wdata_q;
    logic [Lanes-1:0] lane_q;
    logic [Width-1:0] old_q;
    logic [Cw-1:0]    prog_cnt_q;
    logic [Pw-1:0]    word_cnt_q;

    logic [Lanes-1:0] lane_en;
    logic [Width-1:0] bit_mask;
    logic [Width-1:0] merged;
    logic             prog_last;
    logic             sweep_last;
    logic             mem_we;
    logic [Aw-1:0]    mem_waddr;
    logic [Width-1:0] mem_wdata;
`ifdef FLASH_PROG_CHECK_EN
    logic             prog_bad;
`endif

    assign gnt_o = req_i & (state_q == ST_IDLE);

    // A lane counts only when every mask bit in it is set.
    always_comb begin
        lane_en  = '0;
        bit_mask = '0;
        for (int i = 0; i < Lanes; i++) begin
            lane_en[i] = &wmask_i[i*DataBitsPerMask +: DataBitsPerMask];
            bit_mask[i*DataBitsPerMask +: DataBitsPerMask] =
                {DataBitsPerMask{lane_q[i]}};
        end
    end

    // Program can only clear bits in enabled lanes.
    assign merged     = old_q & (wdata_q | ~bit_mask);
    assign prog_last  = (state_q == ST_PROG) && (prog_cnt_q == ProgLast);
    assign sweep_last = &word_cnt_q;

`ifdef FLASH_PROG_CHECK_EN
    assign prog_bad = |(~old_q & wdata_q & bit_mask);
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (1'b1)
            (state_q == ST_ERASE): begin
                mem_we    = 1'b1;
                mem_waddr = {addr_q[Aw-1:Pw], word_cnt_q};
                mem_wdata = '1;
            end
            prog_last: begin
`ifdef FLASH_PROG_CHECK_EN
                mem_we    = ~prog_bad;
`else
                mem_we    = 1'b1;
`endif
                mem_waddr = addr_q;
                mem_wdata = merged;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Array has no reset; state is IDLE during reset so no write happens.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            old_q      <= '0;
            prog_cnt_q <= '0;
            word_cnt_q <= '0;
            rdata_o    <= '0;
            rvalid_o   <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_o) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        lane_q  <= lane_en;
                        old_q   <= mem[addr_i];
                        busy_o  <= 1'b1;
                        unique case (op_i)
                            OpRead: begin
                                rdata_o  <= mem[addr_i];
                                rvalid_o <= 1'b1;
                                state_q  <= ST_READ;
                            end
                            OpProg: begin
                                prog_cnt_q <= '0;
                                state_q    <= ST_PROG;
                            end
                            OpErase: begin
                                word_cnt_q <= '0;
                                state_q    <= ST_ERASE;
                            end
                            OpRsvd: begin
                                done_o  <= 1'b1;
                                err_o   <= 1'b1;
                                state_q <= ST_FIN;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    rvalid_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_PROG: begin
                    if (prog_last) begin
                        done_o  <= 1'b1;
`ifdef FLASH_PROG_CHECK_EN
                        err_o   <= prog_bad;
`else
                        err_o   <= 1'b0;
`endif
                        state_q <= ST_FIN;
                    end else begin
                        prog_cnt_q <= prog_cnt_q + Cw'(1);
                    end
                end
                ST_ERASE: begin
                    if (sweep_last) begin
                        done_o  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        word_cnt_q <= word_cnt_q + Pw'(1);
                    end
                end
                ST_FIN: begin
                    done_o  <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_pe_ctrl.sv
// tb_flash_pe_ctrl: scoreboard bench for flash_pe_ctrl.
// Expected read data / error flags and output cycle are queued at grant.
module tb_flash_pe_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic [1:0]  op_i;
    logic [12:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] wmask_i;
    logic        gnt_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;

    flash_pe_ctrl dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .op_i     (op_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .wmask_i  (wmask_i),
        .gnt_o    (gnt_o),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .busy_o   (busy_o)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
        int          exp_cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] model [8192];
    int          cyc;
    int          n_chk;
    int          n_err;
    int          gc;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops one expectation per rvalid/done pulse.
    always @(negedge clk_i) begin
        if (rst_ni && err_o && !done_o) chk("err_alone", 32'd1, 32'd0);
        if (rst_ni && (rvalid_o || done_o)) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                me = q.pop_front();
                chk("kind", {31'b0, rvalid_o}, {31'b0, me.is_rd});
                if (me.is_rd) chk("rdata", rdata_o, me.data);
                else chk("err", {31'b0, err_o}, {31'b0, me.err});
                chk("latency", cyc, me.exp_cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [12:0] addr,
                         input logic [31:0] wd, input logic [31:0] wm,
                         input bit push, output int gcyc);
        exp_t        e;
        bit          got;
        logic [31:0] bm;
        logic [31:0] old;
        logic [12:0] base;
        bit          bad;
        int          lat;
        @(negedge clk_i);
        req_i   = 1'b1;
        op_i    = op;
        addr_i  = addr;
        wdata_i = wd;
        wmask_i = wm;
        got     = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            #1;
            chk("gnt_idle", {31'b0, gnt_o}, {31'b0, ~busy_o});
            if (gnt_o) got = 1'b1;
            else @(negedge clk_i);
        end
        gcyc = cyc;
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            req_i = 1'b0;
            return;
        end
        e.is_rd = 1'b0;
        e.data  = '0;
        e.err   = 1'b0;
        lat     = 1;
        case (op)
            2'b00: begin
                e.is_rd = 1'b1;
                e.data  = model[addr];
            end
            2'b01: begin
                for (int l = 0; l < 4; l++)
                    bm[l*8 +: 8] = {8{&wm[l*8 +: 8]}};
                old = model[addr];
                bad = |(~old & wd & bm);
`ifdef FLASH_PROG_CHECK_EN
                e.err = bad;
                if (!bad) model[addr] = old & (wd | ~bm);
`else
                model[addr] = old & (wd | ~bm);
`endif
                lat = 5;
            end
            2'b10: begin
                base = {addr[12:8], 8'h00};
                for (int w = 0; w < 256; w++) model[base | 13'(w)] = '1;
                lat = 257;
            end
            default: begin
                e.err = 1'b1;
            end
        endcase
        e.exp_cyc = gcyc + lat;
        if (push) q.push_back(e);
    endtask

    task automatic drop();
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk_i);
            #2;
            if (!busy_o && q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [12:0] addr,
                       input logic [31:0] wd, input logic [31:0] wm);
        int g;
        issue(op, addr, wd, wm, 1'b1, g);
        drop();
        wait_idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},    {31'b0, gnt_o},    32'd0);
        chk({tag, "_rdata"},  rdata_o,           32'd0);
        chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd0);
        chk({tag, "_done"},   {31'b0, done_o},   32'd0);
        chk({tag, "_err"},    {31'b0, err_o},    32'd0);
        chk({tag, "_busy"},   {31'b0, busy_o},   32'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_ni  = 1'b0;
        req_i   = 1'b0;
        op_i    = 2'b00;
        addr_i  = '0;
        wdata_i = '0;
        wmask_i = '0;
        for (int i = 0; i < 8192; i++) model[i] = '1;
        #3;
        chk_reset_vals("rst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run(2'b00, 13'h0010, 32'h0, 32'h0);
        run(2'b01, 13'h0010, 32'h12345678, 32'hFFFFFFFF);
        run(2'b00, 13'h0010, 32'h0, 32'h0);
        run(2'b01, 13'h0010, 32'h00FF0000, 32'h00FF0000);
        run(2'b00, 13'h0010, 32'h0, 32'h0);
        run(2'b01, 13'h0010, 32'hFFFF00FF, 32'h0000FF00);
        run(2'b00, 13'h0010, 32'h0, 32'h0);
        run(2'b01, 13'h0010, 32'h00000000, 32'h00000000);
        run(2'b01, 13'h0010, 32'h00000000, 32'h000000FE);
        run(2'b11, 13'h0010, 32'h00000000, 32'hFFFFFFFF);
        run(2'b00, 13'h0010, 32'h0, 32'h0);

        run(2'b01, 13'h0100, 32'hA5A5A5A5, 32'hFFFFFFFF);
        run(2'b01, 13'h00FF, 32'h00000000, 32'hFFFFFFFF);

        // Back-to-back reads with req held.
        issue(2'b00, 13'h0100, 32'h0, 32'h0, 1'b1, gc);
        issue(2'b00, 13'h0010, 32'h0, 32'h0, 1'b1, gc);
        drop();
        wait_idle();

        // Erase page 0 with a read held pending for the whole sweep.
        issue(2'b10, 13'h0015, 32'h0, 32'h0, 1'b1, gc);
        issue(2'b00, 13'h0100, 32'h0, 32'h0, 1'b1, gc);
        drop();
        wait_idle();
        run(2'b00, 13'h0000, 32'h0, 32'h0);
        run(2'b00, 13'h00FF, 32'h0, 32'h0);
        run(2'b00, 13'h0010, 32'h0, 32'h0);

        // Reset in the middle of an erase sweep.
        run(2'b01, 13'h0000, 32'h44444444, 32'hFFFFFFFF);
        run(2'b01, 13'h0062, 32'h11111111, 32'hFFFFFFFF);
        run(2'b01, 13'h0063, 32'h22222222, 32'hFFFFFFFF);
        run(2'b01, 13'h00FF, 32'h33333333, 32'hFFFFFFFF);
        run(2'b00, 13'h0063, 32'h0, 32'h0);
        issue(2'b10, 13'h0000, 32'h0, 32'h0, 1'b0, gc);
        for (int w = 0; w < 256; w++) model[w] = 32'h22222222;
        model[13'h00] = 32'h44444444;
        model[13'h62] = 32'h11111111;
        model[13'h63] = 32'h22222222;
        model[13'hFF] = 32'h33333333;
        for (int w = 0; w < 13'h63; w++) model[w] = '1;
        drop();
        while (cyc < gc + 100) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("mid");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        run(2'b00, 13'h0000, 32'h0, 32'h0);
        run(2'b00, 13'h0062, 32'h0, 32'h0);
        run(2'b00, 13'h0063, 32'h0, 32'h0);
        run(2'b00, 13'h00FF, 32'h0, 32'h0);
        run(2'b00, 13'h0100, 32'h0, 32'h0);

        repeat (3) @(negedge clk_i);
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
